// File: rtl/eth_pkg.sv
// Shared Ethernet definitions: CRC-32 constants, framing bytes, sizing
// defaults and the FCS appender state encoding.
package eth_pkg;

    localparam logic [31:0] CRC32_POLY           = 32'hEDB88320;
    localparam logic [31:0] CRC32_INIT           = 32'hFFFFFFFF;
    localparam logic [7:0]  ETH_PREAMBLE_BYTE    = 8'h55;
    localparam logic [7:0]  ETH_SFD_BYTE         = 8'hD5;
    localparam int          ETH_MIN_FRAME_OCTETS = 60;
    localparam int          ETH_IFG_OCTETS       = 12;

    typedef enum logic [2:0] {
        ST_PRE,
        ST_DATA,
        ST_PAD,
        ST_FCS,
        ST_IFG
    } fcs_state_t;

endpackage

// File: rtl/eth_crc32_byte.sv
// Combinational one-byte step of the reflected Ethernet CRC-32.
// Data bits are consumed LSB first. The same block is shared with the
// receive-side FCS checker.
module eth_crc32_byte
    import eth_pkg::*;
(
    input  logic [31:0] crc,
    input  logic [7:0]  data,
    output logic [31:0] crc_next
);

    logic [31:0] c;

    // Eight serial shift/xor steps unrolled into one combinational stage
    always_comb begin
        c = crc;
        for (int i = 0; i < 8; i++) begin
            if (c[0] ^ data[i]) begin
                c = (c >> 1) ^ CRC32_POLY;
            end else begin
                c = c >> 1;
            end
        end
        crc_next = c;
    end

endmodule

// File: rtl/eth_fcs_appender.sv
// Ethernet FCS appender: passes preamble/SFD and frame bytes through,
// pads short frames, appends the CRC-32 FCS and then holds off the next
// frame for the inter-frame gap.
module eth_fcs_appender
    import eth_pkg::*;
#(
    parameter int          PREAMBLE_SFD_OCTETS = 8,
    parameter int          MIN_FRAME_OCTETS    = ETH_MIN_FRAME_OCTETS,
    parameter int          IFG_OCTETS          = ETH_IFG_OCTETS,
    parameter logic [7:0]  PAD_BYTE            = 8'h00
)
(
    input  logic       clk,
    input  logic       areset,
    output logic       in_axis_tready,
    input  logic       in_axis_tvalid,
    input  logic       in_axis_tlast,
    input  logic [7:0] in_axis_tdata,
    input  logic       out_axis_tready,
    output logic       out_axis_tvalid,
    output logic       out_axis_tlast,
    output logic [7:0] out_axis_tdata
);

    localparam logic [15:0] PRE_LAST = (PREAMBLE_SFD_OCTETS > 0) ? 16'(PREAMBLE_SFD_OCTETS - 1) : 16'd0;
    localparam logic [15:0] MIN_LEN  = 16'(MIN_FRAME_OCTETS);
    localparam logic [15:0] IFG_LAST = (IFG_OCTETS > 0) ? 16'(IFG_OCTETS - 1) : 16'd0;

    logic [1:0]  rst_pipe;
    logic        rst;
    fcs_state_t  state;
    logic [15:0] cnt;
    logic [15:0] len_cnt;
    logic [15:0] len_next;
    logic [31:0] crc;
    logic [31:0] crc_next;
    logic [31:0] fcs;
    logic [7:0]  fcs_byte;
    logic        beat;

    // Reset asserts immediately with areset but releases two clocks later
    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            rst_pipe <= 2'b11;
        end else begin
            rst_pipe <= {rst_pipe[0], 1'b0};
        end
    end

    assign rst = rst_pipe[1];

    // Frame length grows by one per counted byte and sticks at the minimum
    assign len_next = (len_cnt >= MIN_LEN) ? len_cnt : len_cnt + 16'd1;
    assign fcs      = ~crc;
    assign beat     = out_axis_tvalid & out_axis_tready;

    // The CRC always absorbs whatever byte is leaving in DATA and PAD
    eth_crc32_byte u_crc (
        .crc      (crc),
        .data     (out_axis_tdata),
        .crc_next (crc_next)
    );

    // FCS is sent least significant byte first
    always_comb begin
        fcs_byte = fcs[7:0];
        case (cnt[1:0])
            2'd0:    fcs_byte = fcs[7:0];
            2'd1:    fcs_byte = fcs[15:8];
            2'd2:    fcs_byte = fcs[23:16];
            default: fcs_byte = fcs[31:24];
        endcase
    end

    // Output and ready muxing: zero-latency pass-through in PRE/DATA, locally
    // generated bytes in PAD/FCS, everything idle in IFG and during reset
    always_comb begin
        out_axis_tvalid = 1'b0;
        out_axis_tlast  = 1'b0;
        out_axis_tdata  = 8'h00;
        in_axis_tready  = 1'b0;
        if (!rst) begin
            case (state)
                ST_PRE: begin
                    out_axis_tvalid = in_axis_tvalid;
                    out_axis_tlast  = in_axis_tlast;
                    out_axis_tdata  = in_axis_tdata;
                    in_axis_tready  = out_axis_tready;
                end
                ST_DATA: begin
                    out_axis_tvalid = in_axis_tvalid;
                    out_axis_tdata  = in_axis_tdata;
                    in_axis_tready  = out_axis_tready;
                end
                ST_PAD: begin
                    out_axis_tvalid = 1'b1;
                    out_axis_tdata  = PAD_BYTE;
                end
                ST_FCS: begin
                    out_axis_tvalid = 1'b1;
                    out_axis_tlast  = (cnt[1:0] == 2'd3);
                    out_axis_tdata  = fcs_byte;
                end
                default: begin
                end
            endcase
        end
    end

    // Frame sequencing: state, shared beat/cycle counter, length and CRC
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ST_PRE;
            cnt     <= 16'd0;
            len_cnt <= 16'd0;
            crc     <= CRC32_INIT;
        end else begin
            case (state)
                ST_PRE: begin
                    crc     <= CRC32_INIT;
                    len_cnt <= 16'd0;
                    if (beat) begin
                        if (in_axis_tlast) begin
                            cnt   <= 16'd0;
                            state <= (IFG_OCTETS == 0) ? ST_PRE : ST_IFG;
                        end else if (cnt == PRE_LAST) begin
                            cnt   <= 16'd0;
                            state <= ST_DATA;
                        end else begin
                            cnt <= cnt + 16'd1;
                        end
                    end
                end
                ST_DATA: begin
                    if (beat) begin
                        crc     <= crc_next;
                        len_cnt <= len_next;
                        if (in_axis_tlast) begin
                            cnt   <= 16'd0;
                            state <= (len_next < MIN_LEN) ? ST_PAD : ST_FCS;
                        end
                    end
                end
                ST_PAD: begin
                    if (beat) begin
                        crc     <= crc_next;
                        len_cnt <= len_next;
                        if (len_next >= MIN_LEN) begin
                            cnt   <= 16'd0;
                            state <= ST_FCS;
                        end
                    end
                end
                ST_FCS: begin
                    if (beat) begin
                        if (cnt[1:0] == 2'd3) begin
                            cnt   <= 16'd0;
                            state <= (IFG_OCTETS == 0) ? ST_PRE : ST_IFG;
                        end else begin
                            cnt <= cnt + 16'd1;
                        end
                    end
                end
                ST_IFG: begin
                    if (cnt == IFG_LAST) begin
                        cnt   <= 16'd0;
                        state <= ST_PRE;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                default: begin
                    cnt   <= 16'd0;
                    state <= ST_PRE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_eth_fcs_appender.sv
// Bench for eth_fcs_appender: a default-parameter instance plus a
// no-pad/no-gap instance fed from the same stream, both checked beat by beat
// against a frame-level model.
module tb_eth_fcs_appender;

    typedef logic [7:0] u8;

    logic       clk = 1'b0;
    logic       areset = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_last = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       out_ready = 1'b1;

    logic       in_tready, out_valid, out_last;
    logic [7:0] out_data;
    logic       in0_valid, in0_tready, out0_valid, out0_last;
    logic [7:0] out0_data;

    int  total = 0;
    int  bad = 0;
    u8   exp_d[$];
    bit  exp_l[$];
    u8   exp0_d[$];
    bit  exp0_l[$];
    u8   m_d[$];
    bit  m_l[$];
    u8   cap_q[$];
    u8   cap_b[$];
    bit  cap_en = 1'b0;
    bit  bp_en = 1'b0;
    bit  gap_check = 1'b0;
    bit  gap_armed = 1'b0;
    int  gap_cnt = 0;
    logic [31:0] crc_tab [256];

    u8   frame_a[$];
    u8   frame_b[$];
    u8   frame_c[$];
    u8   frame_bad[$];

    // The second instance only sees bytes the first one is taking
    assign in0_valid = in_valid & in_tready;

    eth_fcs_appender dut (
        .clk             (clk),
        .areset          (areset),
        .in_axis_tready  (in_tready),
        .in_axis_tvalid  (in_valid),
        .in_axis_tlast   (in_last),
        .in_axis_tdata   (in_data),
        .out_axis_tready (out_ready),
        .out_axis_tvalid (out_valid),
        .out_axis_tlast  (out_last),
        .out_axis_tdata  (out_data)
    );

    eth_fcs_appender #(.MIN_FRAME_OCTETS(0), .IFG_OCTETS(0)) dut0 (
        .clk             (clk),
        .areset          (areset),
        .in_axis_tready  (in0_tready),
        .in_axis_tvalid  (in0_valid),
        .in_axis_tlast   (in_last),
        .in_axis_tdata   (in_data),
        .out_axis_tready (out_ready),
        .out_axis_tvalid (out0_valid),
        .out_axis_tlast  (out0_last),
        .out_axis_tdata  (out0_data)
    );

    always #5 clk = ~clk;

    // Output ready: always high, or a coin toss per cycle under backpressure
    always begin
        @(posedge clk);
        #2;
        out_ready = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("[TB] FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    function automatic logic [31:0] crc_update(input logic [31:0] c, input u8 b);
        return (c >> 8) ^ crc_tab[c[7:0] ^ b];
    endfunction

    // Expected output of one offered frame for a given minimum length
    task automatic model_frame(input u8 fr[$], input int min_len);
        u8 body[$];
        logic [31:0] c;
        m_d.delete();
        m_l.delete();
        if (fr.size() <= 8) begin
            foreach (fr[i]) begin
                m_d.push_back(fr[i]);
                m_l.push_back(i == fr.size() - 1);
            end
            return;
        end
        for (int i = 8; i < fr.size(); i++) body.push_back(fr[i]);
        while (body.size() < min_len) body.push_back(8'h00);
        c = 32'hFFFFFFFF;
        foreach (body[i]) c = crc_update(c, body[i]);
        c = ~c;
        for (int i = 0; i < 8; i++) begin
            m_d.push_back(fr[i]);
            m_l.push_back(1'b0);
        end
        foreach (body[i]) begin
            m_d.push_back(body[i]);
            m_l.push_back(1'b0);
        end
        for (int k = 0; k < 4; k++) begin
            m_d.push_back(c[8*k +: 8]);
            m_l.push_back(k == 3);
        end
    endtask

    task automatic send_byte(input u8 b, input bit last);
        bit done = 1'b0;
        in_valid = 1'b1;
        in_data  = b;
        in_last  = last;
        for (int i = 0; i < 300 && !done; i++) begin
            @(negedge clk);
            if (in_tready) done = 1'b1;
        end
        if (done) begin
            @(posedge clk);
            #2;
        end else begin
            check_output("input_accept_timeout", 32'(in_tready), 32'd1);
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic apply_stimulus(input u8 fr[$]);
        model_frame(fr, 60);
        foreach (m_d[i]) begin
            exp_d.push_back(m_d[i]);
            exp_l.push_back(m_l[i]);
        end
        model_frame(fr, 0);
        foreach (m_d[i]) begin
            exp0_d.push_back(m_d[i]);
            exp0_l.push_back(m_l[i]);
        end
        foreach (fr[i]) send_byte(fr[i], i == fr.size() - 1);
    endtask

    task automatic wait_drain();
        bit ok = 1'b0;
        for (int i = 0; i < 3000 && !ok; i++) begin
            @(negedge clk);
            #1;
            if (exp_d.size() == 0 && exp0_d.size() == 0) ok = 1'b1;
        end
        check_output("drain_pending", 32'(exp_d.size() + exp0_d.size()), 32'd0);
        @(posedge clk);
        #2;
    endtask

    task automatic residue_check(input string name);
        logic [31:0] c = 32'hFFFFFFFF;
        for (int i = 8; i < cap_q.size(); i++) c = crc_update(c, cap_q[i]);
        check_output(name, c, 32'hDEBB20E3);
    endtask

    // Per-cycle compare of both instances against the expected queues
    logic       prev_v = 1'b0, prev_r = 1'b0, prev0_v = 1'b0, prev0_r = 1'b0;
    logic [7:0] prev_d = 8'h00, prev0_d = 8'h00;
    u8          ed;
    bit         el;

    always @(negedge clk) begin
        if (areset) begin
            prev_v    = 1'b0;
            prev0_v   = 1'b0;
            gap_armed = 1'b0;
        end else begin
            if (prev_v && !prev_r) begin
                check_output("hold_valid", 32'(out_valid), 32'd1);
                check_output("hold_data", 32'(out_data), 32'(prev_d));
            end
            if (prev0_v && !prev0_r) begin
                check_output("hold0_valid", 32'(out0_valid), 32'd1);
                check_output("hold0_data", 32'(out0_data), 32'(prev0_d));
            end
            if (out_valid && out_ready) begin
                if (gap_armed) check_output("ifg_gap", 32'(gap_cnt), 32'd12);
                gap_armed = out_last && gap_check;
                gap_cnt   = 0;
                if (exp_d.size() == 0) begin
                    check_output("dut_unexpected_beat", 32'(exp_d.size()), 32'd1);
                end else begin
                    ed = exp_d.pop_front();
                    el = exp_l.pop_front();
                    check_output("dut_data", 32'(out_data), 32'(ed));
                    check_output("dut_last", 32'(out_last), 32'(el));
                    if (cap_en) cap_q.push_back(out_data);
                end
            end else if (gap_armed && !out_valid && !in_tready) begin
                gap_cnt++;
            end
            if (out0_valid && out_ready) begin
                if (exp0_d.size() == 0) begin
                    check_output("dut0_unexpected_beat", 32'(exp0_d.size()), 32'd1);
                end else begin
                    ed = exp0_d.pop_front();
                    el = exp0_l.pop_front();
                    check_output("dut0_data", 32'(out0_data), 32'(ed));
                    check_output("dut0_last", 32'(out0_last), 32'(el));
                end
            end
            prev_v  = out_valid;
            prev_r  = out_ready;
            prev_d  = out_data;
            prev0_v = out0_valid;
            prev0_r = out_ready;
            prev0_d = out0_data;
        end
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [31:0] v;
        logic [31:0] c;
        int diffs;

        for (int i = 0; i < 256; i++) begin
            v = 32'(i);
            for (int k = 0; k < 8; k++) v = v[0] ? ((v >> 1) ^ 32'hEDB88320) : (v >> 1);
            crc_tab[i] = v;
        end

        for (int i = 0; i < 7; i++) frame_a.push_back(8'h55);
        frame_a.push_back(8'hD5);
        frame_b = frame_a;
        frame_c = frame_a;
        for (int i = 0; i < 9; i++) frame_a.push_back(8'h31 + 8'(i));
        for (int i = 0; i < 14; i++) begin
            frame_b.push_back(8'h10 + 8'(i));
            frame_c.push_back(8'h10 + 8'(i));
        end
        for (int i = 0; i < 10; i++) frame_b.push_back(8'hA0 + 8'(i));
        for (int i = 0; i < 46; i++) frame_c.push_back(8'(i * 3 + 1));
        for (int i = 0; i < 3; i++) frame_bad.push_back(8'h55);

        // Reset state, with input valid offered so pass-through would show
        in_valid = 1'b1;
        in_data  = 8'hA5;
        #1 areset = 1'b1;
        #2;
        check_output("reset_out_valid", 32'(out_valid), 32'd0);
        check_output("reset_in_ready", 32'(in_tready), 32'd0);
        check_output("reset_in0_ready", 32'(in0_tready), 32'd0);
        check_output("reset_out_data", 32'(out_data), 32'd0);
        check_output("reset_out_last", 32'(out_last), 32'd0);
        in_valid = 1'b0;
        #20 areset = 1'b0;
        @(posedge clk);
        #2;

        // Model pinned to known CRC-32 values
        c = 32'hFFFFFFFF;
        for (int i = 0; i < 9; i++) c = crc_update(c, 8'h31 + 8'(i));
        check_output("model_crc_check", ~c, 32'hCBF43926);
        model_frame(frame_a, 0);
        check_output("model_len_nopad", 32'(m_d.size()), 32'd21);
        check_output("model_fcs0", 32'(m_d[17]), 32'h26);
        check_output("model_fcs1", 32'(m_d[18]), 32'h39);
        check_output("model_fcs2", 32'(m_d[19]), 32'hF4);
        check_output("model_fcs3", 32'(m_d[20]), 32'hCB);
        check_output("model_last", 32'(m_l[20]), 32'd1);
        model_frame(frame_b, 60);
        check_output("model_len_pad", 32'(m_d.size()), 32'd72);

        $display("[TB] check-value frame");
        apply_stimulus(frame_a);
        wait_drain();

        $display("[TB] short frame with padding");
        cap_q.delete();
        cap_en = 1'b1;
        apply_stimulus(frame_b);
        wait_drain();
        cap_en = 1'b0;
        check_output("padded_len", 32'(cap_q.size()), 32'd72);
        residue_check("padded_residue");
        check_output("pad_byte", 32'(cap_q[40]), 32'h00);
        cap_b = cap_q;

        $display("[TB] exact minimum frame");
        cap_q.delete();
        cap_en = 1'b1;
        apply_stimulus(frame_c);
        wait_drain();
        cap_en = 1'b0;
        check_output("exact_len", 32'(cap_q.size()), 32'd72);
        residue_check("exact_residue");

        $display("[TB] backpressure");
        cap_q.delete();
        cap_en = 1'b1;
        bp_en  = 1'b1;
        apply_stimulus(frame_b);
        wait_drain();
        bp_en  = 1'b0;
        cap_en = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        check_output("bp_len", 32'(cap_q.size()), 32'(cap_b.size()));
        diffs = 0;
        for (int i = 0; i < cap_q.size() && i < cap_b.size(); i++)
            if (cap_q[i] !== cap_b[i]) diffs++;
        check_output("bp_sequence_diffs", 32'(diffs), 32'd0);

        $display("[TB] back-to-back frames");
        gap_check = 1'b1;
        apply_stimulus(frame_b);
        apply_stimulus(frame_b);
        wait_drain();
        gap_check = 1'b0;

        $display("[TB] malformed frame");
        apply_stimulus(frame_bad);
        wait_drain();

        $display("[TB] reset mid-payload");
        for (int i = 0; i < 13; i++) begin
            exp_d.push_back(frame_b[i]);
            exp_l.push_back(1'b0);
            exp0_d.push_back(frame_b[i]);
            exp0_l.push_back(1'b0);
        end
        for (int i = 0; i < 13; i++) send_byte(frame_b[i], 1'b0);
        check_output("pre_abort_pending", 32'(exp_d.size()), 32'd0);
        in_valid = 1'b1;
        in_data  = 8'h77;
        #1;
        check_output("pre_abort_valid", 32'(out_valid), 32'd1);
        areset = 1'b1;
        #1;
        check_output("abort_out_valid", 32'(out_valid), 32'd0);
        check_output("abort_in_ready", 32'(in_tready), 32'd0);
        check_output("abort_out_data", 32'(out_data), 32'd0);
        check_output("abort_out0_valid", 32'(out0_valid), 32'd0);
        in_valid = 1'b0;
        exp_d.delete();
        exp_l.delete();
        exp0_d.delete();
        exp0_l.delete();
        repeat (3) @(posedge clk);
        #3 areset = 1'b0;
        @(posedge clk);
        #2;
        cap_q.delete();
        cap_en = 1'b1;
        apply_stimulus(frame_b);
        wait_drain();
        cap_en = 1'b0;
        check_output("after_reset_len", 32'(cap_q.size()), 32'd72);
        residue_check("after_reset_residue");

        repeat (20) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
